led_pattern_gen: RTL and testbench

Multi-channel LED pattern generator driven from the 50 MHz board clock. A shared prescaler produces a 1 ms tick. Each of CH channels runs its own runtime-programmable pattern engine: OFF, ON, BLINK or BURST. Out of reset every channel blinks with a 500 ms half-period, so a single-LED heartbeat needs no configuration.

---
 rtl/led_pattern_gen.sv | 105 ++++++++++
 tb/tb_led_pattern_gen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern generator (OFF/ON/BLINK/BURST) on a shared tick
// Ports:
//   Clk_50M   system clock
//   rst       asynchronous active-low reset
//   cfg_we    one-cycle configuration write strobe
//   cfg_ch    target channel (writes to cfg_ch >= CH are ignored)
//   cfg_mode  0 OFF, 1 ON, 2 BLINK, 3 BURST
//   cfg_half  half-period in ticks (0 is treated as 1)
//   dim       global brightness, only when LED_DIM_EN is defined
//   tick      one-cycle pulse per tick
//   Led       active-high LED drive, one bit per channel
// Optional feature macro: LED_DIM_EN (adds dim port and PWM gate)
module led_pattern_gen #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1000,
   parameter int CH      = 4,
   parameter int PW      = 12
) (
   input  logic          Clk_50M,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [3:0]    cfg_ch,
   input  logic [1:0]    cfg_mode,
   input  logic [PW-1:0] cfg_half,
`ifdef LED_DIM_EN
   input  logic [3:0]    dim,
`endif
   output logic          tick,
   output logic [CH-1:0] Led
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PRW = $clog2(DIV);
   localparam logic [1:0] OFF   = 2'd0;
   localparam logic [1:0] BLINK = 2'd2;
   localparam logic [PW-1:0] HALF_RST = PW'(500);
   logic [PRW-1:0] pre;
   logic [1:0]     mode  [CH];
   logic [PW-1:0]  half  [CH];
   logic [PW-1:0]  cnt   [CH];
   logic [3:0]     phase [CH];
   logic [3:0]     nph   [CH];
   logic [CH-1:0]  led;
   logic [CH-1:0]  wrap;
   assign tick = pre == PRW'(DIV - 1);
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         wrap[i] = cnt[i] == half[i] - 1'b1;
         nph[i]  = phase[i] == 4'd9 ? 4'd0 : phase[i] + 4'd1;
      end
   end
   // a write takes priority over a coinciding tick on the same channel
   always_ff @(posedge Clk_50M or negedge rst) begin
      if (!rst) begin
         pre <= '0;
         for (int i = 0; i < CH; i++) begin
            mode[i]  <= BLINK;
            half[i]  <= HALF_RST;
            cnt[i]   <= '0;
            phase[i] <= '0;
            led[i]   <= 1'b1;
         end
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         for (int i = 0; i < CH; i++) begin
            if (cfg_we && cfg_ch == 4'(i)) begin
               mode[i]  <= cfg_mode;
               half[i]  <= cfg_half == '0 ? PW'(1) : cfg_half;
               cnt[i]   <= '0;
               phase[i] <= '0;
               led[i]   <= cfg_mode != OFF;
            end else if (tick && mode[i][1]) begin
               cnt[i] <= wrap[i] ? '0 : cnt[i] + 1'b1;
               if (wrap[i]) begin
                  if (mode[i][0]) begin
                     phase[i] <= nph[i];
                     led[i]   <= nph[i] < 4'd6 && !nph[i][0];
                  end else
                     led[i] <= ~led[i];
               end
            end
         end
      end
   end
`ifdef LED_DIM_EN
   localparam int PD  = (DIV / 16) < 1 ? 1 : DIV / 16;
   localparam int PCW = PD > 1 ? $clog2(PD) : 1;
   logic [PCW-1:0] pc;
   logic [3:0]     pwm;
   logic           pstep;
   assign pstep = pc == PCW'(PD - 1);
   always_ff @(posedge Clk_50M or negedge rst) begin
      if (!rst) begin
         pc  <= '0;
         pwm <= '0;
      end else begin
         pc <= pstep ? '0 : pc + 1'b1;
         if (pstep) pwm <= pwm + 4'd1;
      end
   end
   // widened compare so dim=15 keeps the gate permanently open
   assign Led = led & {CH{{1'b0, pwm} < {1'b0, dim} + 5'd1}};
`else
   assign Led = led;
`endif
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed self-checking bench for led_pattern_gen with DIV=10
module tb_led_pattern_gen;
   logic        Clk_50M = 1'b0;
   logic        rst = 1'b0;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_ch = '0;
   logic [1:0]  cfg_mode = '0;
   logic [11:0] cfg_half = '0;
   logic        tick;
   logic [3:0]  Led;
   int          errs = 0;
   int          checks = 0;
   int          e = 0;
   int          hi;
`ifdef LED_DIM_EN
   logic [3:0]  dim = 4'd15;
`endif
   led_pattern_gen #(.CLK_HZ(1000), .TICK_HZ(100), .CH(4), .PW(12)) dut (
      .Clk_50M(Clk_50M),
      .rst(rst),
      .cfg_we(cfg_we),
      .cfg_ch(cfg_ch),
      .cfg_mode(cfg_mode),
      .cfg_half(cfg_half),
`ifdef LED_DIM_EN
      .dim(dim),
`endif
      .tick(tick),
      .Led(Led)
   );
   always #5 Clk_50M = ~Clk_50M;
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s at edge %0d: got %h expected %h", tag, e, obs, exp);
      end
   endtask
   task automatic to_edge(input int n);
      repeat (n - e) @(posedge Clk_50M);
      #1;
      e = n;
   endtask
   task automatic wr(input logic [3:0] ch, input logic [1:0] m, input logic [11:0] h);
      cfg_we = 1'b1;
      cfg_ch = ch;
      cfg_mode = m;
      cfg_half = h;
      @(posedge Clk_50M);
      #1;
      cfg_we = 1'b0;
      e++;
   endtask
   initial begin
      #22;
      chk("rst_led", 16'(Led), 16'hF);
      chk("rst_tick", 16'(tick), 16'h0);
      @(negedge Clk_50M);
      rst = 1'b1;
      e = 0;
      to_edge(8);    chk("tick_e8", 16'(tick), 16'h0);
      to_edge(9);    chk("tick_e9", 16'(tick), 16'h1);
      to_edge(10);   chk("tick_e10", 16'(tick), 16'h0);
      to_edge(19);   chk("tick_e19", 16'(tick), 16'h1);
      to_edge(4999); chk("blink_4999", 16'(Led), 16'hF);
      to_edge(5000); chk("blink_5000", 16'(Led), 16'h0);
      to_edge(9999); chk("blink_9999", 16'(Led), 16'h0);
      to_edge(10000); chk("blink_10000", 16'(Led), 16'hF);
      wr(4'd1, 2'd3, 12'd2);
      chk("burst_wr", 16'(Led), 16'hF);
      to_edge(10019); chk("burst_p0", 16'(Led), 16'hF);
      to_edge(10020); chk("burst_p1", 16'(Led), 16'hD);
      to_edge(10040); chk("burst_p2", 16'(Led), 16'hF);
      to_edge(10060); chk("burst_p3", 16'(Led), 16'hD);
      to_edge(10080); chk("burst_p4", 16'(Led), 16'hF);
      to_edge(10100); chk("burst_p5", 16'(Led), 16'hD);
      to_edge(10120); chk("burst_p6", 16'(Led), 16'hD);
      to_edge(10199); chk("burst_p9", 16'(Led), 16'hD);
      to_edge(10200); chk("burst_wrap", 16'(Led), 16'hF);
      wr(4'd2, 2'd0, 12'd5);
      chk("off_ch2", 16'(Led), 16'hB);
      wr(4'd7, 2'd0, 12'd5);
      chk("ign_ch7", 16'(Led), 16'hB);
      to_edge(14999); chk("ign_14999", 16'(Led), 16'h9);
      to_edge(15000); chk("ign_15000", 16'(Led), 16'h2);
      wr(4'd3, 2'd1, 12'd5);
      chk("on_ch3", 16'(Led), 16'hA);
      to_edge(15009);
      wr(4'd0, 2'd2, 12'd0);
      chk("col_wr", 16'(Led), 16'hB);
      to_edge(15019); chk("col_ignored", 16'(Led), 16'hB);
      to_edge(15020); chk("col_t1", 16'(Led), 16'h8);
      to_edge(15029); chk("col_t1b", 16'(Led), 16'h8);
      to_edge(15030); chk("col_t2", 16'(Led), 16'h9);
      to_edge(15040); chk("col_t3", 16'(Led), 16'hA);
      to_edge(15145);
      rst = 1'b0;
      #1;
      chk("rst_mid_led", 16'(Led), 16'hF);
      chk("rst_mid_tick", 16'(tick), 16'h0);
      repeat (3) @(negedge Clk_50M);
      rst = 1'b1;
      e = 0;
      to_edge(9);    chk("rel_tick9", 16'(tick), 16'h1);
      to_edge(4999); chk("rel_4999", 16'(Led), 16'hF);
      to_edge(5000); chk("rel_5000", 16'(Led), 16'h0);
`ifdef LED_DIM_EN
      wr(4'd0, 2'd1, 12'd1);
      dim = 4'd3;
      hi = 0;
      for (int k = 0; k < 16; k++) begin
         @(posedge Clk_50M);
         #1;
         e++;
         hi += int'(Led[0]);
      end
      chk("dim3_duty", 16'(hi), 16'd4);
      dim = 4'd15;
      hi = 0;
      for (int k = 0; k < 16; k++) begin
         @(posedge Clk_50M);
         #1;
         e++;
         hi += int'(Led[0]);
      end
      chk("dim15_duty", 16'(hi), 16'd16);
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
